// File: rtl/instr_fetch_unit.sv
// Fetch stage: reads imem at the PC, captures the word into IR, and drives PC+4 or a redirect target back to prog_cntr.
// Latency: fetch_en -> imem_req next cycle; imem_ack -> ir_valid/pc_ld next cycle.
// Backpressure: the IR is held in HOLD until ir_ready; a REQ cycle waits for imem_ack with no timeout.
module instr_fetch_unit #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned PC_STEP = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc_count,
    output logic            pc_ld,
    output logic [XLEN-1:0] pc_data,
    input  logic            fetch_en,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_addr,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] ir,
    output logic [XLEN-1:0] ir_pc,
    output logic            ir_valid,
    input  logic            ir_ready,
    output logic            misalign_fault
);

    typedef enum logic [1:0] {IDLE, REQ, HOLD, FAULT} state_t;

    state_t          state, state_nxt;
    logic            redir_pend, pend_nxt;
    logic [XLEN-1:0] redir_addr, pend_addr_nxt;
    logic [XLEN-1:0] addr_nxt, ld_val;
    logic            ld_go, cap, valid_nxt, fault_nxt;
    logic            load_req;
    logic [XLEN-1:0] load_tgt;

    assign imem_req = (state == REQ);
    // A fresh redirect outranks one parked from an earlier cycle.
    assign load_req = redirect_valid | redir_pend;
    assign load_tgt = redirect_valid ? redirect_addr : redir_addr;

    always_comb begin
        state_nxt     = state;
        pend_nxt      = redir_pend;
        pend_addr_nxt = redir_addr;
        addr_nxt      = imem_addr;
        ld_go         = 1'b0;
        ld_val        = pc_data;
        cap           = 1'b0;
        valid_nxt     = ir_valid;
        fault_nxt     = misalign_fault;
        case (state)
            REQ: begin
                if (redirect_valid) begin
                    pend_nxt      = 1'b1;
                    pend_addr_nxt = redirect_addr;
                end
                if (imem_ack) begin
                    ld_go = 1'b1;
                    if (load_req) begin
                        ld_val    = load_tgt;
                        pend_nxt  = 1'b0;
                        state_nxt = IDLE;
                    end else begin
                        ld_val    = imem_addr + XLEN'(PC_STEP);
                        cap       = 1'b1;
                        valid_nxt = 1'b1;
                        state_nxt = HOLD;
                    end
                end
            end
            default: begin
                if (load_req) begin
                    state_nxt = IDLE;
                    valid_nxt = 1'b0;
                    fault_nxt = 1'b0;
                    // Park the target for a cycle so pc_ld never pulses back-to-back.
                    if (pc_ld) begin
                        pend_nxt      = 1'b1;
                        pend_addr_nxt = load_tgt;
                    end else begin
                        ld_go    = 1'b1;
                        ld_val   = load_tgt;
                        pend_nxt = 1'b0;
                    end
                end else if (state == IDLE) begin
                    // pc_count is stale while a load is landing in prog_cntr.
                    if (fetch_en && !pc_ld) begin
                        if (pc_count[1:0] == 2'b00) begin
                            addr_nxt  = pc_count;
                            state_nxt = REQ;
                        end else begin
                            fault_nxt = 1'b1;
                            state_nxt = FAULT;
                        end
                    end
                end else if (state == HOLD) begin
                    if (ir_ready) begin
                        valid_nxt = 1'b0;
                        state_nxt = IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            redir_pend     <= 1'b0;
            redir_addr     <= '0;
            imem_addr      <= '0;
            pc_ld          <= 1'b0;
            pc_data        <= '0;
            ir             <= '0;
            ir_pc          <= '0;
            ir_valid       <= 1'b0;
            misalign_fault <= 1'b0;
        end else begin
            state          <= state_nxt;
            redir_pend     <= pend_nxt;
            redir_addr     <= pend_addr_nxt;
            imem_addr      <= addr_nxt;
            pc_ld          <= ld_go;
            if (ld_go) pc_data <= ld_val;
            if (cap) begin
                ir    <= imem_rdata;
                ir_pc <= imem_addr;
            end
            ir_valid       <= valid_nxt;
            misalign_fault <= fault_nxt;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: per-cycle vector table plus hand sequences for reset, hold and redirect corners.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc_count = '0;
    logic        pc_ld;
    logic [31:0] pc_data;
    logic        fetch_en = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_addr = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] ir;
    logic [31:0] ir_pc;
    logic        ir_valid;
    logic        ir_ready = 1'b0;
    logic        misalign_fault;

    int total = 0;
    int bad   = 0;

    instr_fetch_unit #(.XLEN(32), .PC_STEP(4)) dut (
        .clk(clk), .rst(rst), .pc_count(pc_count), .pc_ld(pc_ld), .pc_data(pc_data),
        .fetch_en(fetch_en), .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .ir(ir), .ir_pc(ir_pc), .ir_valid(ir_valid), .ir_ready(ir_ready),
        .misalign_fault(misalign_fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, fen, rv;
        logic [31:0] raddr, pc;
        logic        ack;
        logic [31:0] rdata;
        logic        rdy;
        logic        e_req, e_ld;
        logic [31:0] e_pd, e_ir, e_irpc;
        logic        e_irv, e_flt;
    } vec_t;

    vec_t vecs[21];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v, input int i);
        rst = v.rst; fetch_en = v.fen; redirect_valid = v.rv; redirect_addr = v.raddr;
        pc_count = v.pc; imem_ack = v.ack; imem_rdata = v.rdata; ir_ready = v.rdy;
        tick();
        chk($sformatf("v%0d.imem_req", i), {31'b0, imem_req}, {31'b0, v.e_req});
        chk($sformatf("v%0d.pc_ld", i), {31'b0, pc_ld}, {31'b0, v.e_ld});
        chk($sformatf("v%0d.pc_data", i), pc_data, v.e_pd);
        chk($sformatf("v%0d.ir", i), ir, v.e_ir);
        chk($sformatf("v%0d.ir_pc", i), ir_pc, v.e_irpc);
        chk($sformatf("v%0d.ir_valid", i), {31'b0, ir_valid}, {31'b0, v.e_irv});
        chk($sformatf("v%0d.fault", i), {31'b0, misalign_fault}, {31'b0, v.e_flt});
    endtask

    task automatic set_in(input logic f, input logic r, input logic [31:0] ra, input logic [31:0] pc,
                          input logic a, input logic [31:0] rd, input logic rdy);
        fetch_en = f; redirect_valid = r; redirect_addr = ra; pc_count = pc;
        imem_ack = a; imem_rdata = rd; ir_ready = rdy;
    endtask

    initial begin
        //            rst fen rv raddr       pc            ack rdata          rdy  req ld pd            ir             irpc          irv flt
        vecs[0]  = '{1, 0, 0, 32'h0,    32'h0,        0, 32'h0,        0,   0, 0, 32'h0,        32'h0,        32'h0,        0, 0};
        vecs[1]  = '{1, 0, 0, 32'h0,    32'h0,        0, 32'h0,        0,   0, 0, 32'h0,        32'h0,        32'h0,        0, 0};
        vecs[2]  = '{0, 1, 0, 32'h0,    32'h100,      0, 32'h0,        0,   1, 0, 32'h0,        32'h0,        32'h0,        0, 0};
        vecs[3]  = '{0, 0, 0, 32'h0,    32'h100,      0, 32'h0,        0,   1, 0, 32'h0,        32'h0,        32'h0,        0, 0};
        vecs[4]  = '{0, 0, 0, 32'h0,    32'h100,      0, 32'h0,        0,   1, 0, 32'h0,        32'h0,        32'h0,        0, 0};
        vecs[5]  = '{0, 0, 0, 32'h0,    32'h100,      1, 32'h00500093, 0,   0, 1, 32'h104,      32'h00500093, 32'h100,      1, 0};
        vecs[6]  = '{0, 0, 0, 32'h0,    32'h104,      0, 32'h0,        0,   0, 0, 32'h104,      32'h00500093, 32'h100,      1, 0};
        vecs[7]  = '{0, 0, 0, 32'h0,    32'h104,      0, 32'h0,        1,   0, 0, 32'h104,      32'h00500093, 32'h100,      0, 0};
        vecs[8]  = '{0, 1, 0, 32'h0,    32'hFFFFFFFC, 0, 32'h0,        0,   1, 0, 32'h104,      32'h00500093, 32'h100,      0, 0};
        vecs[9]  = '{0, 0, 0, 32'h0,    32'hFFFFFFFC, 1, 32'h13,       0,   0, 1, 32'h0,        32'h13,       32'hFFFFFFFC, 1, 0};
        vecs[10] = '{0, 0, 0, 32'h0,    32'h0,        0, 32'h0,        1,   0, 0, 32'h0,        32'h13,       32'hFFFFFFFC, 0, 0};
        vecs[11] = '{0, 1, 0, 32'h0,    32'h102,      0, 32'h0,        0,   0, 0, 32'h0,        32'h13,       32'hFFFFFFFC, 0, 1};
        vecs[12] = '{0, 1, 0, 32'h0,    32'h102,      0, 32'h0,        0,   0, 0, 32'h0,        32'h13,       32'hFFFFFFFC, 0, 1};
        vecs[13] = '{0, 0, 1, 32'h200,  32'h102,      0, 32'h0,        0,   0, 1, 32'h200,      32'h13,       32'hFFFFFFFC, 0, 0};
        vecs[14] = '{0, 0, 0, 32'h0,    32'h200,      0, 32'h0,        0,   0, 0, 32'h200,      32'h13,       32'hFFFFFFFC, 0, 0};
        vecs[15] = '{0, 1, 0, 32'h0,    32'h200,      0, 32'h0,        0,   1, 0, 32'h200,      32'h13,       32'hFFFFFFFC, 0, 0};
        vecs[16] = '{0, 0, 0, 32'h0,    32'h200,      1, 32'hAAAA,     0,   0, 1, 32'h204,      32'hAAAA,     32'h200,      1, 0};
        // Redirect lands while pc_ld is high: deferred one cycle, beats ir_ready.
        vecs[17] = '{0, 0, 1, 32'h300,  32'h204,      0, 32'h0,        1,   0, 0, 32'h204,      32'hAAAA,     32'h200,      0, 0};
        vecs[18] = '{0, 0, 0, 32'h0,    32'h204,      0, 32'h0,        0,   0, 1, 32'h300,      32'hAAAA,     32'h200,      0, 0};
        vecs[19] = '{0, 1, 0, 32'h0,    32'h300,      0, 32'h0,        0,   0, 0, 32'h300,      32'hAAAA,     32'h200,      0, 0};
        vecs[20] = '{0, 1, 0, 32'h0,    32'h300,      0, 32'h0,        0,   1, 0, 32'h300,      32'hAAAA,     32'h200,      0, 0};

        for (int i = 0; i < 21; i++) run_vec(vecs[i], i);

        // Reset for two cycles while in REQ; a late ack afterwards is ignored.
        rst = 1'b1; set_in(0, 0, 0, 32'h300, 0, 0, 0);
        tick();
        chk("rst.imem_req", {31'b0, imem_req}, 32'h0);
        chk("rst.ir_valid", {31'b0, ir_valid}, 32'h0);
        chk("rst.fault", {31'b0, misalign_fault}, 32'h0);
        chk("rst.ir", ir, 32'h0);
        tick();
        rst = 1'b0; set_in(0, 0, 0, 32'h300, 1, 32'hDEAD, 0);
        tick();
        chk("late_ack.ir", ir, 32'h0);
        chk("late_ack.ir_valid", {31'b0, ir_valid}, 32'h0);
        chk("late_ack.pc_ld", {31'b0, pc_ld}, 32'h0);
        chk("late_ack.imem_req", {31'b0, imem_req}, 32'h0);

        // HOLD backpressure: IR stable, fetch_en ignored.
        set_in(1, 0, 0, 32'h10, 0, 0, 0);
        tick();
        chk("hold.req", {31'b0, imem_req}, 32'h1);
        set_in(0, 0, 0, 32'h10, 1, 32'h12345678, 0);
        tick();
        chk("hold.ir", ir, 32'h12345678);
        chk("hold.pc_data", pc_data, 32'h14);
        for (int k = 0; k < 5; k++) begin
            set_in(1, 0, 0, 32'h14, 0, 0, 0);
            tick();
            chk($sformatf("hold%0d.ir", k), ir, 32'h12345678);
            chk($sformatf("hold%0d.ir_valid", k), {31'b0, ir_valid}, 32'h1);
            chk($sformatf("hold%0d.imem_req", k), {31'b0, imem_req}, 32'h0);
        end
        set_in(0, 0, 0, 32'h14, 0, 0, 1);
        tick();
        chk("hold_rel.ir_valid", {31'b0, ir_valid}, 32'h0);
        set_in(1, 0, 0, 32'h14, 0, 0, 0);
        tick();
        chk("refetch.req", {31'b0, imem_req}, 32'h1);
        chk("refetch.addr", imem_addr, 32'h14);
        set_in(0, 0, 0, 32'h14, 1, 32'h11111111, 0);
        tick();
        chk("refetch.ir", ir, 32'h11111111);
        chk("refetch.pc_data", pc_data, 32'h18);
        set_in(0, 0, 0, 32'h18, 0, 0, 1);
        tick();

        // Redirect during REQ, ack two cycles later: word discarded.
        set_in(1, 0, 0, 32'h18, 0, 0, 0);
        tick();
        chk("rreq.addr", imem_addr, 32'h18);
        set_in(0, 1, 32'h80, 32'h18, 0, 0, 0);
        tick();
        chk("rreq.req_held", {31'b0, imem_req}, 32'h1);
        chk("rreq.pc_ld_quiet", {31'b0, pc_ld}, 32'h0);
        set_in(0, 0, 0, 32'h18, 0, 0, 0);
        tick();
        set_in(0, 0, 0, 32'h18, 1, 32'hBEEF, 0);
        tick();
        chk("rreq.ir", ir, 32'h11111111);
        chk("rreq.ir_valid", {31'b0, ir_valid}, 32'h0);
        chk("rreq.pc_ld", {31'b0, pc_ld}, 32'h1);
        chk("rreq.pc_data", pc_data, 32'h80);
        chk("rreq.req_drop", {31'b0, imem_req}, 32'h0);
        set_in(0, 0, 0, 32'h18, 0, 0, 0);
        tick();
        chk("rreq.pc_ld_once", {31'b0, pc_ld}, 32'h0);

        // Last redirect seen in REQ wins.
        set_in(1, 0, 0, 32'h80, 0, 0, 0);
        tick();
        set_in(0, 1, 32'h90, 32'h80, 0, 0, 0);
        tick();
        set_in(0, 1, 32'hA0, 32'h80, 0, 0, 0);
        tick();
        set_in(0, 0, 0, 32'h80, 1, 32'h7777, 0);
        tick();
        chk("last.pc_data", pc_data, 32'hA0);
        chk("last.ir", ir, 32'h11111111);
        set_in(0, 0, 0, 32'hA0, 0, 0, 0);
        tick();

        // Ack and redirect in the same cycle: redirect wins.
        set_in(1, 0, 0, 32'hA0, 0, 0, 0);
        tick();
        set_in(0, 1, 32'hC0, 32'hA0, 1, 32'h5555, 0);
        tick();
        chk("same.pc_data", pc_data, 32'hC0);
        chk("same.pc_ld", {31'b0, pc_ld}, 32'h1);
        chk("same.ir", ir, 32'h11111111);
        chk("same.ir_valid", {31'b0, ir_valid}, 32'h0);
        set_in(0, 0, 0, 32'hC0, 0, 0, 0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
